// File: rtl/task_pkg.sv
// Shared definitions for the test_task arithmetic core and its result buffer.
package task_pkg;

    parameter int WIDTH = 8;
    localparam int RES_W = 2 * WIDTH;

    typedef logic signed [RES_W-1:0] res_t;

    // Ceiling log2, used to size pointers and counters at elaboration time.
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/task_valid_pipe.sv
// Valid delay line matched to test_task latency; its last stage marks the
// cycle in which the core's result is present on y.
module task_valid_pipe #(
    parameter int LATENCY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic push_req
);

    logic [LATENCY-1:0] stage;

    // Shift the issue strobe one stage per clock; cleared by reset so that
    // in-flight results are forgotten.
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the previous stage's old value, giving a true shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage <= '0;
        end else begin
            stage[0] <= in_valid;
            for (int i = 1; i < LATENCY; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign push_req = stage[LATENCY-1];

endmodule

// File: rtl/task_result_buffer.sv
// Captures test_task results into a show-ahead FIFO and presents them on a
// valid/ready port; results arriving with no room are counted as drops.
module task_result_buffer
    import task_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4,
    parameter int DROP_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic signed [RES_W-1:0]   y,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic signed [RES_W-1:0]   m_data,
    output logic [clog2(DEPTH):0]     count,
    output logic                      full,
    output logic [DROP_W-1:0]         drop_cnt
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic          push_req;
    logic          push;
    logic          pop;
    logic          drop;
    logic          empty;
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic [DROP_W-1:0] drop_q;
    res_t          mem [DEPTH];

    task_valid_pipe #(
        .LATENCY (LATENCY)
    ) u_valid_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .push_req (push_req)
    );

    // Pointers carry one extra wrap bit, so their difference is the occupancy
    // and always equals the running sum of pushes minus pops.
    assign count = wr_ptr - rd_ptr;
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    assign pop  = m_valid & m_ready;
    assign push = push_req & (~full | pop);
    assign drop = push_req & full & ~pop;

    // Head presentation: a freshly pushed entry only becomes visible after the
    // write clock edge, so there is no empty-FIFO bypass.
    // NOTE: every output of this always_comb is given a default first, so no
    // path can leave a value unassigned and infer a latch.
    always_comb begin
        m_valid = 1'b0;
        m_data  = '0;
        if (!empty) begin
            m_valid = 1'b1;
            m_data  = mem[rd_ptr[AW-1:0]];
        end
    end

    // Result storage; y is written directly from the core without a staging
    // register.
    // NOTE: the storage array has no reset; stale contents are unreachable
    // because m_data is forced to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= y;
        end
    end

    // Read/write pointers with natural wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + CW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + CW'(1);
            end
        end
    end

    // Saturating count of results lost for lack of room.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= '0;
        end else if (drop && (drop_q != {DROP_W{1'b1}})) begin
            drop_q <= drop_q + DROP_W'(1);
        end
    end

    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_task_result_buffer.sv
// Self-checking bench for task_result_buffer. A behavioural stand-in for
// test_task feeds y; a queue-based model tracks what the buffer must hold.
module tb_task_result_buffer;
    import task_pkg::*;

    localparam int LATENCY = 2;
    localparam int DEPTH   = 4;
    localparam int DROP_W  = 8;
    localparam int CW      = $clog2(DEPTH) + 1;
    localparam int MAXD    = (1 << DROP_W) - 1;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              m_ready;
    logic signed [7:0] a, b, c, d;
    res_t              y;
    logic              m_valid;
    res_t              m_data;
    logic [CW-1:0]     count;
    logic              full;
    logic [DROP_W-1:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int   due;
        res_t val;
    } pend_t;

    typedef struct {
        logic signed [7:0] a, b, c, d;
        logic [15:0]       exp;
    } vec_t;

    res_t  q[$];
    pend_t pend[$];
    int    drops = 0;
    res_t  yp [LATENCY];

    task_result_buffer #(
        .LATENCY (LATENCY),
        .DEPTH   (DEPTH),
        .DROP_W  (DROP_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .y        (y),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .count    (count),
        .full     (full),
        .drop_cnt (drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int calc_y(input int ia, input int ib, input int ic, input int id);
        return ((ia - ib) * (1 + 3 * ic) - 4 * id) / 2;
    endfunction

    // Stand-in for test_task: result appears LATENCY clocks after its operands.
    always @(posedge clk) begin
        yp[0] <= 16'(calc_y(a, b, c, d));
        for (int i = 1; i < LATENCY; i++) yp[i] <= yp[i-1];
    end
    assign y = yp[LATENCY-1];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic compare_model();
        res_t head;
        head = (q.size() > 0) ? q[0] : res_t'(0);
        check("m_valid", 16'(m_valid), 16'(q.size() > 0));
        check("m_data", m_data, head);
        check("count", 16'(count), 16'(q.size()));
        check("full", 16'(full), 16'(q.size() == DEPTH));
        check("drop_cnt", 16'(drop_cnt), 16'(drops));
    endtask

    // Commit the model for the current cycle's inputs, advance one clock,
    // then compare the DUT against the model.
    task automatic tick();
        bit   do_pop;
        bit   arrive;
        bit   was_full;
        res_t aval;
        if (!rst) begin
            do_pop   = (q.size() > 0) && m_ready;
            arrive   = 1'b0;
            aval     = '0;
            was_full = (q.size() == DEPTH);
            if (pend.size() > 0 && pend[0].due == cyc) begin
                arrive = 1'b1;
                aval   = pend[0].val;
                void'(pend.pop_front());
            end
            if (do_pop) void'(q.pop_front());
            if (arrive) begin
                if (!was_full || do_pop) q.push_back(aval);
                else if (drops < MAXD) drops++;
            end
            if (in_valid) pend.push_back('{cyc + LATENCY, 16'(calc_y(a, b, c, d))});
        end
        @(posedge clk);
        #1;
        cyc++;
        compare_model();
    endtask

    task automatic issue(input int ia, input int ib, input int ic, input int id);
        a = 8'(ia); b = 8'(ib); c = 8'(ic); d = 8'(id);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        q.delete();
        pend.delete();
        drops = 0;
        check("rst_m_valid", 16'(m_valid), 16'h0);
        check("rst_m_data", m_data, 16'h0);
        check("rst_count", 16'(count), 16'h0);
        check("rst_full", 16'(full), 16'h0);
        check("rst_drop_cnt", 16'(drop_cnt), 16'h0);
        repeat (2) @(posedge clk);
        #1;
        cyc += 2;
        rst = 1'b0;
    endtask

    vec_t vecs[3];

    initial begin
        rst = 1'b0; in_valid = 1'b0; m_ready = 1'b0;
        a = '0; b = '0; c = '0; d = '0;
        #2;
        do_reset();

        // Single result with consumer ready.
        m_ready = 1'b1;
        issue(1, 1, 1, 1);
        repeat (LATENCY - 1) tick();
        check("t1_not_early", 16'(m_valid), 16'h0);
        tick();
        check("t1_m_valid", 16'(m_valid), 16'h1);
        check("t1_m_data", m_data, 16'hFFFE);
        tick();
        check("t1_count_zero", 16'(count), 16'h0);

        // Table of back-to-back issues, drained in order.
        vecs[0] = '{8'sd1,   8'sd1, 8'sd1, 8'sd1, 16'hFFFE};
        vecs[1] = '{8'sd4,   8'sd3, 8'sd3, 8'sd1, 16'h0003};
        vecs[2] = '{8'sd127, 8'sd0, 8'sd0, 8'sd0, 16'h003F};
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) issue(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d);
        repeat (LATENCY) tick();
        check("t2_count3", 16'(count), 16'h3);
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t2_pop%0d", i), m_data, vecs[i].exp);
            tick();
        end
        m_ready = 1'b0;
        check("t2_empty", 16'(count), 16'h0);

        // Overflow: DEPTH+2 issues, consumer stalled.
        for (int i = 0; i < DEPTH + 2; i++) issue(2 * (i + 1), 0, 0, 0);
        repeat (LATENCY) tick();
        check("t3_count", 16'(count), 16'(DEPTH));
        check("t3_full", 16'(full), 16'h1);
        check("t3_drops", 16'(drop_cnt), 16'h2);
        check("t3_head", m_data, 16'h1);

        // Full with push_req and pop in the same cycle.
        issue(0, 5, 2, -3);
        repeat (LATENCY - 1) tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("t4_count", 16'(count), 16'(DEPTH));
        check("t4_drops", 16'(drop_cnt), 16'h2);
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("t4_order%0d", i), m_data,
                  (i == DEPTH - 1) ? 16'hFFF5 : 16'(i + 2));
            tick();
        end
        m_ready = 1'b0;
        check("t4_empty", 16'(m_valid), 16'h0);

        // Reset with stored and in-flight results.
        for (int i = 0; i < 3; i++) issue(10 + i, 0, 0, 0);
        repeat (LATENCY) tick();
        check("t5_count3", 16'(count), 16'h3);
        issue(50, 0, 0, 0);
        issue(52, 0, 0, 0);
        do_reset();
        repeat (LATENCY + 1) tick();
        check("t5_no_old", 16'(count), 16'h0);
        issue(7, 1, 0, 0);
        repeat (LATENCY) tick();
        check("t5_fresh_count", 16'(count), 16'h1);
        check("t5_fresh_data", m_data, 16'h3);

        // Drop counter saturation.
        for (int i = 0; i < DEPTH + (1 << DROP_W) + 5; i++) issue(i % 100, 0, 0, 0);
        repeat (LATENCY + 1) tick();
        check("t6_sat", 16'(drop_cnt), 16'(MAXD));

        // Randomised traffic against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            c = 8'($urandom); d = 8'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            m_ready  = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                            : ($urandom_range(0, 3) == 0);
            tick();
        end
        in_valid = 1'b0;
        m_ready  = 1'b1;
        repeat (LATENCY + DEPTH + 2) tick();
        check("final_drain", 16'(count), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
